bp_cfg_streamer: RTL

BP_CFG_STREAMER -- requirements
Module: bp_cfg_streamer

---
 rtl/bp_cfg_streamer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bp_cfg_streamer.sv
// Streams one configuration as a header word, field_count_p field words and an
// XOR checksum word over a valid/ready config bus.
module bp_cfg_streamer #(
    parameter int field_count_p  = 20,
    parameter int field_width_p  = 32,
    parameter int addr_width_p   = 8,
    parameter int cfg_id_width_p = 7
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    start_i,
    input  logic [cfg_id_width_p-1:0]               cfg_id_i,
    input  logic [field_count_p*field_width_p-1:0]  cfg_fields_i,
    output logic                                    v_o,
    output logic [addr_width_p-1:0]                 addr_o,
    output logic [field_width_p-1:0]                data_o,
    input  logic                                    ready_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    err_o
);

    localparam int IDX_W = (field_count_p > 1) ? $clog2(field_count_p) : 1;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(field_count_p - 1);
    localparam logic [addr_width_p-1:0] CHK_ADDR = addr_width_p'(field_count_p + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_FIELDS   = 3'd2,
        ST_CHECKSUM = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    function automatic logic [field_width_p-1:0] sel_field(
        input logic [field_count_p*field_width_p-1:0] fields,
        input logic [IDX_W-1:0]                       k
    );
        sel_field = fields[int'(k)*field_width_p +: field_width_p];
    endfunction

    state_t                               r_state;
    logic [cfg_id_width_p-1:0]            r_cfg_id;
    logic [field_count_p*field_width_p-1:0] r_fields;
    logic [IDX_W-1:0]                     r_idx;
    logic [field_width_p-1:0]             r_acc;
    logic [addr_width_p-1:0]              r_addr;
    logic [field_width_p-1:0]             r_data;
    logic                                 r_v;
    logic                                 r_busy;
    logic                                 r_done;
    logic                                 r_err;

    state_t                               w_state_nxt;
    logic [cfg_id_width_p-1:0]            w_cfg_id_nxt;
    logic [field_count_p*field_width_p-1:0] w_fields_nxt;
    logic [IDX_W-1:0]                     w_idx_nxt;
    logic [field_width_p-1:0]             w_acc_nxt;
    logic [addr_width_p-1:0]              w_addr_nxt;
    logic [field_width_p-1:0]             w_data_nxt;
    logic                                 w_v_nxt;
    logic                                 w_busy_nxt;
    logic                                 w_done_nxt;
    logic                                 w_err_nxt;
    logic                                 w_xfer;

    assign w_xfer = r_v & ready_i;

    // Next-state and next-output decode; the bus word for the next state is
    // prepared here so addr/data leave a register aligned with v.
    always_comb begin
        w_state_nxt  = r_state;
        w_cfg_id_nxt = r_cfg_id;
        w_fields_nxt = r_fields;
        w_idx_nxt    = r_idx;
        w_acc_nxt    = r_acc;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_err_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (cfg_id_i != {cfg_id_width_p{1'b0}}) begin
                        w_state_nxt  = ST_HEADER;
                        w_cfg_id_nxt = cfg_id_i;
                        w_fields_nxt = cfg_fields_i;
                        w_idx_nxt    = {IDX_W{1'b0}};
                        w_acc_nxt    = {field_width_p{1'b0}};
                        w_addr_nxt   = {addr_width_p{1'b0}};
                        w_data_nxt   = field_width_p'(cfg_id_i);
                    end else begin
                        w_err_nxt    = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FIELDS;
                    w_acc_nxt   = field_width_p'(r_cfg_id);
                    w_idx_nxt   = {IDX_W{1'b0}};
                    w_addr_nxt  = addr_width_p'(1);
                    w_data_nxt  = sel_field(r_fields, {IDX_W{1'b0}});
                end else begin
                    w_state_nxt = ST_HEADER;
                end
            end
            ST_FIELDS: begin
                if (w_xfer) begin
                    w_acc_nxt = r_acc ^ r_data;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_CHECKSUM;
                        w_addr_nxt  = CHK_ADDR;
                        w_data_nxt  = r_acc ^ r_data;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_addr_nxt  = r_addr + addr_width_p'(1);
                        w_data_nxt  = sel_field(r_fields, r_idx + IDX_W'(1));
                    end
                end else begin
                    w_state_nxt = ST_FIELDS;
                end
            end
            ST_CHECKSUM: begin
                if (w_xfer) begin
                    w_state_nxt = ST_DONE;
                    w_addr_nxt  = {addr_width_p{1'b0}};
                    w_data_nxt  = {field_width_p{1'b0}};
                end else begin
                    w_state_nxt = ST_CHECKSUM;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        case (w_state_nxt)
            ST_HEADER, ST_FIELDS, ST_CHECKSUM: w_v_nxt = 1'b1;
            default:                           w_v_nxt = 1'b0;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= ST_IDLE;
            r_cfg_id <= {cfg_id_width_p{1'b0}};
            r_fields <= {(field_count_p*field_width_p){1'b0}};
            r_idx    <= {IDX_W{1'b0}};
            r_acc    <= {field_width_p{1'b0}};
            r_addr   <= {addr_width_p{1'b0}};
            r_data   <= {field_width_p{1'b0}};
            r_v      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cfg_id <= w_cfg_id_nxt;
            r_fields <= w_fields_nxt;
            r_idx    <= w_idx_nxt;
            r_acc    <= w_acc_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_v      <= w_v_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign v_o    = r_v;
    assign addr_o = r_addr;
    assign data_o = r_data;
    assign busy_o = r_busy;
    assign done_o = r_done;
    assign err_o  = r_err;

endmodule
